// File: rtl/memcheck_stream.sv
// Streaming read-side checker: consumes a programmed number of beats and compares every byte
// against a pattern byte. It reports a saturating mismatch count and the index of the first bad beat.
module memcheck_stream #(
  parameter int dataWidth = 512,
  parameter int cntWidth  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ext_data_i_valid,
  output logic                 ext_data_i_ready,
  input  logic [dataWidth-1:0] ext_data_i_bits,
  input  logic [31:0]          ext_csr_i_0,
  input  logic [cntWidth-1:0]  ext_csr_i_1,
  input  logic                 ext_start_i,
  output logic                 ext_busy_o,
  output logic [cntWidth-1:0]  ext_csr_o_0,
  output logic [cntWidth-1:0]  ext_csr_o_1
);

  localparam int NumBytes = dataWidth / 8;
  localparam int MisWidth = $clog2(NumBytes + 1);
  localparam logic [cntWidth-1:0] AllOnes = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              r_state;
  logic [7:0]          r_pattern;
  logic [cntWidth-1:0] r_total;
  logic [cntWidth-1:0] r_beat;
  logic [cntWidth-1:0] r_count;
  logic [cntWidth-1:0] r_index;

  logic                w_accept;
  logic [MisWidth-1:0] w_mism;
  logic [cntWidth:0]   w_sum;
  logic [cntWidth-1:0] w_count_next;
  logic                w_unused_csr;

  // Bits [31:8] of the pattern CSR are reserved.
  assign w_unused_csr = ^ext_csr_i_0[31:8];

  assign ext_data_i_ready = (r_state == RUN);
  assign ext_busy_o       = (r_state == RUN);
  assign w_accept         = ext_data_i_valid && ext_data_i_ready;
  assign ext_csr_o_0      = r_count;
  assign ext_csr_o_1      = r_index;

  always_comb begin
    // NOTE: default assignment first so the combinational block never infers a latch.
    w_mism = '0;
    for (int i = 0; i < NumBytes; i++) begin
      if (ext_data_i_bits[8*i +: 8] != r_pattern) w_mism = w_mism + MisWidth'(1);
    end
  end

  // One spare carry bit in the sum detects overflow, so the count can clamp instead of wrapping.
  assign w_sum        = {1'b0, r_count} + (cntWidth + 1)'(w_mism);
  assign w_count_next = w_sum[cntWidth] ? AllOnes : w_sum[cntWidth-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      r_state   <= IDLE;
      r_pattern <= '0;
      r_total   <= '0;
      r_beat    <= '0;
      r_count   <= '0;
      r_index   <= AllOnes;
    end else begin
      case (r_state)
        IDLE: begin
          if (ext_start_i) begin
            r_count <= '0;
            r_index <= AllOnes;
            r_beat  <= '0;
            if (ext_csr_i_1 != '0) begin
              r_pattern <= ext_csr_i_0[7:0];
              r_total   <= ext_csr_i_1;
              r_state   <= RUN;
            end
          end
        end
        RUN: begin
          if (w_accept) begin
            r_count <= w_count_next;
            if (w_mism != '0 && r_index == AllOnes) r_index <= r_beat;
            r_beat <= r_beat + cntWidth'(1);
            if (r_beat == r_total - cntWidth'(1)) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memcheck_stream.sv
// Self-checking bench for memcheck_stream: directed scenarios plus randomized runs.
// A byte-level reference model predicts the results, and a narrow second instance exercises count saturation.
module tb_memcheck_stream;

  localparam int DW = 512;
  localparam int CW = 32;
  localparam int NB = DW / 8;
  localparam logic [CW-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          ready;
  logic [DW-1:0] bits;
  logic [31:0]   csr0;
  logic [CW-1:0] csr1;
  logic          start;
  logic          busy;
  logic [CW-1:0] o0;
  logic [CW-1:0] o1;

  // Narrow instance: 8 bytes per beat, 4-bit counters.
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_bits;
  logic [31:0] s_csr0;
  logic [3:0]  s_csr1;
  logic        s_start;
  logic        s_busy;
  logic [3:0]  s_o0;
  logic [3:0]  s_o1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] beats[$];

  always #5 clk = ~clk;

  memcheck_stream #(.dataWidth(DW), .cntWidth(CW)) u_dut (
    .clk(clk), .rst(rst),
    .ext_data_i_valid(valid), .ext_data_i_ready(ready), .ext_data_i_bits(bits),
    .ext_csr_i_0(csr0), .ext_csr_i_1(csr1), .ext_start_i(start),
    .ext_busy_o(busy), .ext_csr_o_0(o0), .ext_csr_o_1(o1)
  );

  memcheck_stream #(.dataWidth(64), .cntWidth(4)) u_dut_s (
    .clk(clk), .rst(rst),
    .ext_data_i_valid(s_valid), .ext_data_i_ready(s_ready), .ext_data_i_bits(s_bits),
    .ext_csr_i_0(s_csr0), .ext_csr_i_1(s_csr1), .ext_start_i(s_start),
    .ext_busy_o(s_busy), .ext_csr_o_0(s_o0), .ext_csr_o_1(s_o1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Number of bytes in a beat that differ from the pattern.
  function automatic int ref_mism(input logic [DW-1:0] b, input logic [7:0] pat);
    int n = 0;
    for (int i = 0; i < NB; i++) if (b[8*i +: 8] != pat) n++;
    return n;
  endfunction

  function automatic logic [DW-1:0] make_beat(input logic [7:0] pat, input int err_pct);
    logic [DW-1:0] b;
    logic [7:0]    v;
    for (int i = 0; i < NB; i++) begin
      v = pat;
      if ($urandom_range(99) < err_pct) v = pat ^ 8'($urandom_range(255, 1));
      b[8*i +: 8] = v;
    end
    return b;
  endfunction

  // Runs one check over beats[0..total-1]. mode: 0 = valid held high, 1 = valid toggles, 2 = random stalls.
  // In noisy mode, start and the CSRs are scrambled every cycle of the run.
  task automatic do_run(input logic [7:0] pat, input int total, input int mode, input bit noisy,
                        input string tag);
    int            sent    = 0;
    int            cyc     = 0;
    int            budget  = total * 20 + 20;
    longint        exp_cnt = 0;
    logic [CW-1:0] exp_idx = ONES;
    logic          acc;
    int            m;
    valid = 1'b0;
    csr0  = {24'($urandom), pat};
    csr1  = CW'(total);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (sent < total && cyc < budget) begin
      case (mode)
        0:       valid = 1'b1;
        1:       valid = (cyc % 2 == 0);
        default: valid = ($urandom_range(99) >= 30);
      endcase
      bits = beats[sent];
      if (noisy) begin
        start = 1'($urandom_range(1));
        csr0  = $urandom;
        csr1  = CW'($urandom_range(8, 1));
      end
      check({tag, "_ready"}, 64'(ready), 64'(1));
      check({tag, "_busy"}, 64'(busy), 64'(1));
      acc = valid;
      tick();
      cyc++;
      if (acc) begin
        m = ref_mism(beats[sent], pat);
        if (m != 0 && exp_idx == ONES) exp_idx = CW'(sent);
        exp_cnt = exp_cnt + m;
        if (exp_cnt > longint'(ONES)) exp_cnt = longint'(ONES);
        sent++;
        check({tag, "_count"}, 64'(o0), 64'(exp_cnt));
        check({tag, "_index"}, 64'(o1), 64'(exp_idx));
      end
    end
    valid = 1'b0;
    start = 1'b0;
    check({tag, "_done"}, 64'(sent), 64'(total));
    if (mode == 0) check({tag, "_cycles"}, 64'(cyc), 64'(total));
    check({tag, "_busy_end"}, 64'(busy), 64'(0));
    check({tag, "_ready_end"}, 64'(ready), 64'(0));
    // A beat offered while idle must not be consumed or disturb the results.
    valid = 1'b1;
    bits  = ~{NB{pat}};
    tick();
    check({tag, "_idle_ready"}, 64'(ready), 64'(0));
    check({tag, "_idle_count"}, 64'(o0), 64'(exp_cnt));
    check({tag, "_idle_index"}, 64'(o1), 64'(exp_idx));
    valid = 1'b0;
  endtask

  initial begin
    logic [7:0]    pat;
    logic [DW-1:0] b;
    int            total;
    int            errp;

    rst = 1'b1; valid = 1'b1; bits = '0; csr0 = '0; csr1 = '0; start = 1'b0;
    s_valid = 1'b0; s_bits = '0; s_csr0 = '0; s_csr1 = '0; s_start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_count", 64'(o0), 64'(0));
    check("rst_index", 64'(o1), 64'(ONES));
    check("rst_s_index", 64'(s_o1), 64'(4'hF));
    tick();
    check("idle_no_ready", 64'(ready), 64'(0));
    valid = 1'b0;

    // Clean run.
    beats.delete();
    for (int i = 0; i < 4; i++) beats.push_back({NB{8'hA5}});
    do_run(8'hA5, 4, 0, 1'b0, "clean");
    check("clean_count_k", 64'(o0), 64'(0));
    check("clean_index_k", 64'(o1), 64'(ONES));

    // Single-error run: beat 1 carries 0xFF in bytes 0 and 63.
    beats.delete();
    for (int i = 0; i < 3; i++) beats.push_back('0);
    b = '0;
    b[7:0] = 8'hFF;
    b[DW-1 -: 8] = 8'hFF;
    beats[1] = b;
    do_run(8'h00, 3, 0, 1'b0, "single");
    check("single_count_k", 64'(o0), 64'(2));
    check("single_index_k", 64'(o1), 64'(1));

    // Multi-error run with stalls: beats 2 and 4 fully wrong.
    beats.delete();
    for (int i = 0; i < 5; i++) beats.push_back((i == 2 || i == 4) ? {NB{8'hC3}} : {NB{8'h3C}});
    do_run(8'h3C, 5, 1, 1'b0, "multi");
    check("multi_count_k", 64'(o0), 64'(128));
    check("multi_index_k", 64'(o1), 64'(2));

    // Run leaving count=7, then a zero-length start clears the results.
    beats.delete();
    b = {NB{8'h11}};
    for (int i = 0; i < 7; i++) b[8*i +: 8] = 8'h22;
    beats.push_back(b);
    beats.push_back({NB{8'h11}});
    do_run(8'h11, 2, 0, 1'b0, "seven");
    check("seven_count_k", 64'(o0), 64'(7));
    csr1  = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_busy", 64'(busy), 64'(0));
    check("zero_ready", 64'(ready), 64'(0));
    check("zero_count", 64'(o0), 64'(0));
    check("zero_index", 64'(o1), 64'(ONES));
    tick();
    check("zero_busy2", 64'(busy), 64'(0));

    // Start pulses and CSR changes during a run are ignored.
    beats.delete();
    for (int i = 0; i < 6; i++) beats.push_back(make_beat(8'h5A, 10));
    do_run(8'h5A, 6, 2, 1'b1, "noisy");

    // Reset after 2 of 6 beats.
    beats.delete();
    for (int i = 0; i < 6; i++) beats.push_back(make_beat(8'h77, 50));
    csr0 = 32'h77; csr1 = 6; start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bits = beats[i];
      tick();
    end
    check("mid_count_pre", 64'(o0), 64'(ref_mism(beats[0], 8'h77) + ref_mism(beats[1], 8'h77)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_ready", 64'(ready), 64'(0));
    check("mid_rst_count", 64'(o0), 64'(0));
    check("mid_rst_index", 64'(o1), 64'(ONES));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_accept", 64'(ready), 64'(0));
    end
    valid = 1'b0;
    beats.delete();
    beats.push_back(make_beat(8'h42, 20));
    do_run(8'h42, 1, 0, 1'b0, "after_rst");

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      pat   = 8'($urandom);
      total = $urandom_range(10, 1);
      case ($urandom_range(2))
        0:       errp = 0;
        1:       errp = 2;
        default: errp = 50;
      endcase
      beats.delete();
      for (int i = 0; i < total; i++) beats.push_back(make_beat(pat, errp));
      do_run(pat, total, 2, 1'($urandom_range(1)), $sformatf("rand%0d", r));
    end

    // Saturation on the narrow instance: 8 bad bytes per beat, limit 15.
    s_csr0 = 32'h0; s_csr1 = 4'd3; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("sat_busy", 64'(s_busy), 64'(1));
    s_valid = 1'b1;
    s_bits  = '1;
    tick();
    check("sat_count1", 64'(s_o0), 64'(8));
    check("sat_index1", 64'(s_o1), 64'(0));
    tick();
    check("sat_count2", 64'(s_o0), 64'(15));
    tick();
    check("sat_count3", 64'(s_o0), 64'(15));
    check("sat_busy_end", 64'(s_busy), 64'(0));
    s_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memcheck_stream.md
Name: memcheck_stream

Overview:
- Streaming read-side checker accelerator: the consumer counterpart to the memset streamer.
- Consumes a fixed number of data beats from the streamer read port and compares every byte against a CSR-programmed pattern byte.
- Reports the total mismatching byte count and the index of the first mismatching beat.
- Sits behind the same CSR/start/busy accelerator shell as the other stream accelerators; it has no output data stream.

Parameters:
- dataWidth, 512, data beat width in bits; must be a multiple of 8.
- cntWidth, 32, width of the beat counter and result counters.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous reset, active-high.
- ext_data_i_valid  input  1  input beat valid.
- ext_data_i_ready  output  1  input beat ready.
- ext_data_i_bits  input  dataWidth  input beat payload.
- ext_csr_i_0  input  32  [7:0] = expected pattern byte; [31:8] ignored.
- ext_csr_i_1  input  cntWidth  number of beats to check.
- ext_start_i  input  1  start pulse.
- ext_busy_o  output  1  high while a check is in progress.
- ext_csr_o_0  output  cntWidth  mismatching byte count of the last run (saturating).
- ext_csr_o_1  output  cntWidth  beat index of the first mismatch; all-ones if none.

Behaviour:
- Reset: FSM=IDLE; ext_data_i_ready=0; ext_busy_o=0; ext_csr_o_0=0; ext_csr_o_1=all-ones; internal beat counter=0. Reset mid-run aborts immediately and never accepts a further beat.
- FSM states: IDLE, RUN.
- IDLE:
  - ready=0, busy=0; results hold their last values.
  - ext_start_i=1 with ext_csr_i_1!=0: latch pattern byte and beat total, clear the mismatch count to 0, set first-index to all-ones, clear the beat counter. Next cycle -> RUN.
  - ext_start_i=1 with ext_csr_i_1==0: clear results (count=0, index=all-ones) and stay IDLE; busy never asserts.
- RUN:
  - ready=1, busy=1, both combinational from state.
  - A beat is accepted when valid&ready.
  - On accept:
    - bytewise compare of all dataWidth/8 bytes against the latched pattern; m = popcount of mismatching bytes.
    - count <= min(count + m, 2^cntWidth-1), saturating.
    - if m!=0 and index==all-ones: index <= current beat counter value.
    - beat counter += 1.
  - Accept of beat number total-1: next cycle -> IDLE; ready and busy drop in that same next cycle. Results are final once busy is low.
  - ext_start_i while in RUN is ignored; latched CSRs are not re-sampled.
  - valid low stalls with no state change. CSR input changes during RUN have no effect.
- Latency:
  - start to ready = 1 cycle.
  - Results update in the cycle after each accept.
  - busy falls 1 cycle after the final handshake.
- Compare is single-cycle with no pipeline; the popcount adder tree is sized for dataWidth/8 inputs.
- ready never asserts in IDLE; beats presented in IDLE are not consumed.

Test Plan:
- Clean run: pattern 0xA5, total=4, four beats of all-0xA5 with valid held high -> ready for exactly 4 cycles; busy high 4 cycles; count=0; index=0xFFFFFFFF.
- Single-error run: pattern 0x00, total=3; beat 1 has bytes 0 and 63 = 0xFF -> count=2; index=1.
- Multi-error run with stalls: pattern 0x3C, total=5, valid toggling 1-0-1; beats 2 and 4 fully wrong -> count=128; index=2; busy spans all stalls.
- Zero-length start: ext_csr_i_1=0 with start after a prior run with count=7 -> busy stays 0; ready stays 0; count=0; index=all-ones.
- Start during RUN and CSR change mid-run: second start and pattern change at beat 1 -> ignored; results reflect the original pattern and total.
- Reset mid-run: assert rst after 2 of 6 beats -> next cycle busy=0, ready=0, count=0, index=all-ones; a subsequent start with total=1 completes normally.
